mem_burst_ctrl: RTL
===================

Name:
mem_burst_ctrl

Overview:
Initiator/controller for the team's single-port synchronous RAM block, which has separate read and write address ports and one-cycle registered read data. It accepts burst commands (base address, length, direction) on a valid/ready interface. Write data comes in on a stream and is written sequentially; read data is fetched sequentially and delivered on an output stream with backpressure. It drives the RAM's CS/RE/WE/address/data pins directly and sits between a DMA-style client and one RAM instance.

Parameters:
WIDTH, 8, data word width; must match the RAM.
DEPTH, 8, RAM word count; need not be a power of two.
AW, $clog2(DEPTH), address width (derived, not overridden).

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command offered
CMD_READY  output  1  controller accepts command
CMD_WRITE  input  1  1 = write burst, 0 = read burst
CMD_ADDR  input  AW  burst start address
CMD_LEN  input  AW+1  burst length in words, 0..DEPTH
WR_VALID  input  1  write data beat offered
WR_READY  output  1  write beat accepted
WR_DATA  input  WIDTH  write data
RD_VALID  output  1  read data beat valid
RD_READY  input  1  consumer accepts read beat
RD_DATA  output  WIDTH  read data
DONE  output  1  one-cycle pulse at burst completion
BUSY  output  1  high whenever state is not IDLE
MEM_CS  output  1  RAM chip select
MEM_RE  output  1  RAM read enable
MEM_WE  output  1  RAM write enable
MEM_WADDR  output  AW  RAM write address
MEM_RADDR  output  AW  RAM read address
MEM_WDATA  output  WIDTH  RAM write data
MEM_RDATA  input  WIDTH  RAM registered read data
MEM_RESET  output  1  RAM synchronous clear; tied 0 unless the optional feature is enabled

Behaviour:
- States: IDLE, WRITE, READ, DRAIN, FINISH. Async RESET forces IDLE, cur_addr=0, remaining=0, rd_pending=0. No RAM access while RESET is high; RAM contents are untouched.
- Reset values: CMD_READY=1 (IDLE), WR_READY=0, RD_VALID=0, DONE=0, BUSY=0, all MEM_* controls 0.
- IDLE: CMD_READY=1. On CMD_VALID, latch address, length and direction.
  - LEN=0: go to FINISH with no RAM access.
  - LEN>DEPTH: clamp to DEPTH.
  - Otherwise go to WRITE or READ.
- WRITE: WR_READY=1. On each WR_VALID&&WR_READY, in the same cycle: MEM_CS=MEM_WE=1, MEM_WADDR=cur_addr, MEM_WDATA=WR_DATA (combinational). Then cur_addr advances and remaining decrements. After the last beat, go to FINISH. WR_VALID gaps stall without penalty.
- READ: issue when (!rd_pending || RD_READY).
  - An issue drives MEM_CS=MEM_RE=1 and MEM_RADDR=cur_addr, then sets rd_pending.
  - The cycle after an issue, RD_VALID=1 and RD_DATA=MEM_RDATA (pass-through). The RAM output register holds the word until the next RE.
  - rd_pending clears on RD_VALID&&RD_READY with no new issue.
  - Peak throughput is one word per cycle.
  - After the last issue, go to DRAIN.
- DRAIN: no issues. When the final beat is accepted, go to FINISH.
- FINISH: DONE=1 for exactly one cycle, then IDLE. The next command can be accepted the following cycle.
- Address wrap: cur_addr equal to DEPTH-1 increments to 0, including for non-power-of-two DEPTH.
- Backpressure: while RD_VALID&&!RD_READY, RD_DATA is stable and MEM_RE=0.
- MEM_WE and MEM_RE are never asserted in the same cycle. MEM_CS=0 whenever neither is asserted.
- Reset mid-burst: immediate return to IDLE with no DONE. A partially written burst remains in RAM.

Optional Feature:
CLEAR_CMD_EN.
- Defined: adds input CMD_CLEAR (1 bit), sampled with CMD_VALID in IDLE. CMD_CLEAR=1 overrides CMD_WRITE and CMD_LEN. The controller enters a CLEAR state that drives MEM_CS=MEM_RESET=1 for one cycle, then goes to FINISH (DONE pulse).
- Undefined: no CMD_CLEAR port, no CLEAR state, MEM_RESET tied 0.

Test Plan:
- Write burst addr=2 len=4 data A1,B2,C3,D4, then read burst addr=2 len=4 with RD_READY=1 -> RD_DATA A1,B2,C3,D4 on consecutive cycles; DONE pulses once per burst.
- Write addr=6 len=4 (DEPTH=8) -> MEM_WADDR sequence 6,7,0,1; read back addr=6 len=4 returns the same data.
- Read len=3 with RD_READY held low 3 cycles after the first RD_VALID -> RD_DATA stable, MEM_RE=0 during the stall, all 3 words delivered in order.
- CMD_LEN=0 -> DONE one cycle after acceptance, MEM_CS never asserted; CMD_LEN=DEPTH+1 clamps to DEPTH beats.
- Assert RESET after 2 of 4 write beats -> outputs return to reset values immediately, no DONE; words 0-1 readable afterwards, words 2-3 unchanged.
- With CLEAR_CMD_EN: clear command -> one cycle of MEM_CS=MEM_RESET=1, then DONE; a subsequent read returns all 0.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// ---------------------------------------------------------------------------
// mem_burst_ctrl
//
// Burst initiator for a single-port synchronous RAM that has separate read
// and write address ports and a one-cycle registered read data output.
// A client hands over burst commands (start address, length, direction) on a
// valid/ready channel. Write bursts consume a data stream and write it to
// consecutive addresses. Read bursts fetch consecutive words and deliver them
// on an output stream with backpressure. Addresses wrap from DEPTH-1 to 0.
//
// Optional feature macro: CLEAR_CMD_EN
//   When defined, adds the CMD_CLEAR input and a CLEAR state that pulses
//   MEM_CS/MEM_RESET for one cycle to clear the RAM. When undefined,
//   MEM_RESET is tied low and there is no CMD_CLEAR port.
//
// Ports:
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   CMD_VALID/READY     command handshake
//   CMD_WRITE           1 = write burst, 0 = read burst
//   CMD_ADDR, CMD_LEN   burst start address, length in words (0..DEPTH)
//   CMD_CLEAR           (CLEAR_CMD_EN only) clear-the-RAM command
//   WR_VALID/READY/DATA write data stream into the controller
//   RD_VALID/READY/DATA read data stream out of the controller
//   DONE                one-cycle pulse when a burst completes
//   BUSY                high whenever the controller is not idle
//   MEM_*               RAM pins: CS, RE, WE, WADDR, RADDR, WDATA, RDATA, RESET
// ---------------------------------------------------------------------------
module mem_burst_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_WRITE,
  input  logic [AW-1:0]    CMD_ADDR,
  input  logic [AW:0]      CMD_LEN,
`ifdef CLEAR_CMD_EN
  input  logic             CMD_CLEAR,
`endif
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [WIDTH-1:0] WR_DATA,
  output logic             RD_VALID,
  input  logic             RD_READY,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             DONE,
  output logic             BUSY,
  output logic             MEM_CS,
  output logic             MEM_RE,
  output logic             MEM_WE,
  output logic [AW-1:0]    MEM_WADDR,
  output logic [AW-1:0]    MEM_RADDR,
  output logic [WIDTH-1:0] MEM_WDATA,
  input  logic [WIDTH-1:0] MEM_RDATA,
  output logic             MEM_RESET
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    FINISH
`ifdef CLEAR_CMD_EN
    , CLEAR
`endif
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [AW:0]   remaining;
  logic          rd_pending;   // a fetched word is (or will next cycle be) on MEM_RDATA

  logic          wr_fire;
  logic          rd_issue;
  logic          rd_accept;
  logic          clr_active;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len_clamped;
  logic [AW-1:0] addr_inc;
  state_t        accept_state;

  // Wrap explicitly at DEPTH-1 so non-power-of-two depths stay in range.
  assign addr_inc = (cur_addr == LAST_ADDR) ? '0 : cur_addr + AW'(1);

  // An out-of-range start address (only possible for non-power-of-two
  // DEPTH) folds back into the RAM rather than addressing missing words.
  assign start_addr  = (CMD_ADDR > LAST_ADDR) ? CMD_ADDR - AW'(DEPTH) : CMD_ADDR;
  assign len_clamped = (CMD_LEN > DEPTH_LEN) ? DEPTH_LEN : CMD_LEN;

  always_comb begin
    if (len_clamped == '0) begin
      accept_state = FINISH;
    end else if (CMD_WRITE) begin
      accept_state = WRITE;
    end else begin
      accept_state = READ;
    end
`ifdef CLEAR_CMD_EN
    if (CMD_CLEAR) begin
      accept_state = CLEAR;
    end
`endif
  end

  assign wr_fire   = (state == WRITE) && WR_VALID;
  // A new fetch may overwrite the RAM output register only once the word
  // currently presented has been taken (or none is presented).
  assign rd_issue  = (state == READ) && (!rd_pending || RD_READY);
  assign rd_accept = rd_pending && RD_READY;

`ifdef CLEAR_CMD_EN
  assign clr_active = (state == CLEAR);
`else
  assign clr_active = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      rd_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CMD_VALID) begin
            cur_addr  <= start_addr;
            remaining <= len_clamped;
            state     <= accept_state;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            cur_addr  <= addr_inc;
            remaining <= remaining - 1'b1;
            if (remaining == (AW + 1)'(1)) begin
              state <= FINISH;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            rd_pending <= 1'b1;
            cur_addr   <= addr_inc;
            remaining  <= remaining - 1'b1;
            if (remaining == (AW + 1)'(1)) begin
              state <= DRAIN;
            end
          end else if (rd_accept) begin
            rd_pending <= 1'b0;
          end
        end
        DRAIN: begin
          if (!rd_pending || RD_READY) begin
            rd_pending <= 1'b0;
            state      <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
`ifdef CLEAR_CMD_EN
        CLEAR: begin
          state <= FINISH;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake/status outputs decode straight from the state register.
  assign CMD_READY = (state == IDLE);
  assign WR_READY  = (state == WRITE);
  assign BUSY      = (state != IDLE);
  assign DONE      = (state == FINISH);
  assign RD_VALID  = rd_pending;
  // The RAM output register holds its word until the next read enable,
  // so a pass-through is stable under backpressure.
  assign RD_DATA   = MEM_RDATA;

  assign MEM_WE    = wr_fire;
  assign MEM_RE    = rd_issue;
  assign MEM_RESET = clr_active;
  assign MEM_CS    = wr_fire | rd_issue | clr_active;
  assign MEM_WADDR = wr_fire  ? cur_addr : '0;
  assign MEM_RADDR = rd_issue ? cur_addr : '0;
  assign MEM_WDATA = wr_fire  ? WR_DATA  : '0;

endmodule
